// File: rtl/g_reduce_rx_pkg.sv
// ============================================================================
//  Module      : g_reduce_rx_pkg
//  Description : Shared constants and FSM encoding for the g-stage receiver.
//                Defines `Datawidth (coefficient width) when not set by the
//                build. The optional macro G_RX_STATS_EN is consumed by
//                g_reduce_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef Datawidth
`define Datawidth 16
`endif

package g_reduce_rx_pkg;

    // Default modulus for the final correction
    localparam int C_MOD_DEFAULT = 3329;

    // Width of the signed g sample arriving from the g-stage
    localparam int C_G_W = `Datawidth + 3;

    // Correction FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CORR = 2'd1,
        ST_OUT  = 2'd2
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/g_rx_fifo.sv
// ============================================================================
//  Module      : g_rx_fifo
//  Description : DEPTH x WIDTH synchronous FIFO with first-word fall-through
//                read data. A push into a full FIFO is accepted only when a
//                pop happens on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module g_rx_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == c_cw'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap freely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/g_reduce_rx.sv
// ============================================================================
//  Module      : g_reduce_rx
//  Description : Receiver for the g-stage output. Buffers strobed signed g
//                samples, reduces each into [0, MOD) with at most MAX_CORR
//                add/subtract steps and presents the result on valid/ready.
//                Optional macro G_RX_STATS_EN adds rx_cnt / drop_cnt outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef Datawidth
`define Datawidth 16
`endif

module g_reduce_rx
    import g_reduce_rx_pkg::*;
#(
    parameter int DW       = `Datawidth,
    parameter int MOD      = C_MOD_DEFAULT,
    parameter int DEPTH    = 4,
    parameter int MAX_CORR = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW+2:0] g_in,
    input  logic          g_vld,
    output logic [DW-1:0] r,
    output logic          r_vld,
    input  logic          r_rdy,
    output logic          r_err,
    output logic          ovf
`ifdef G_RX_STATS_EN
    ,
    output logic [15:0]   rx_cnt,
    output logic [15:0]   drop_cnt
`endif
);

    localparam int c_gw = DW + 3;
    localparam int c_aw = DW + 4;
    localparam int c_sw = $clog2(MAX_CORR + 1);
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam logic signed [c_aw-1:0] c_mod = c_aw'(MOD);

    rx_state_t              r_state;
    rx_state_t              w_state_nxt;
    logic signed [c_aw-1:0] r_acc;
    logic signed [c_aw-1:0] w_acc_nxt;
    logic [c_sw-1:0]        r_step;
    logic [c_sw-1:0]        w_step_nxt;
    logic [DW-1:0]          r_res;
    logic [DW-1:0]          w_res_nxt;
    logic                   r_res_vld;
    logic                   w_res_vld_nxt;
    logic                   r_res_err;
    logic                   w_res_err_nxt;
    logic                   r_ovf;

    logic [c_gw-1:0]        w_head;
    logic [c_cw-1:0]        w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_neg;
    logic                   w_hi;

    // A sample is taken whenever there is room, including the slot freed by
    // a same-edge pop; anything else arriving on g_vld is lost.
    assign w_pop  = (r_state == ST_IDLE) && !w_empty;
    assign w_push = g_vld && (!w_full || w_pop);
    assign w_drop = g_vld && !w_push;

    assign w_neg  = r_acc[c_aw-1];
    assign w_hi   = (r_acc >= c_mod);

    g_rx_fifo #(
        .WIDTH (c_gw),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (g_in),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // State, accumulator and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_step    <= '0;
            r_res     <= '0;
            r_res_vld <= 1'b0;
            r_res_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_step    <= w_step_nxt;
            r_res     <= w_res_nxt;
            r_res_vld <= w_res_vld_nxt;
            r_res_err <= w_res_err_nxt;
        end
    end

    // Correction FSM: load, fold by +/-MOD one step per cycle, then present
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_step_nxt    = r_step;
        w_res_nxt     = r_res;
        w_res_vld_nxt = r_res_vld;
        w_res_err_nxt = r_res_err;
        case (r_state)
            ST_IDLE: begin
                if (w_count != '0) begin
                    w_acc_nxt   = {w_head[c_gw-1], w_head};
                    w_step_nxt  = '0;
                    w_state_nxt = ST_CORR;
                end
            end
            ST_CORR: begin
                if (w_neg || w_hi) begin
                    if (r_step == c_sw'(MAX_CORR)) begin
                        // Step budget exhausted: report instead of looping on
                        w_res_nxt     = '0;
                        w_res_err_nxt = 1'b1;
                        w_res_vld_nxt = 1'b1;
                        w_state_nxt   = ST_OUT;
                    end else begin
                        w_acc_nxt  = w_neg ? (r_acc + c_mod) : (r_acc - c_mod);
                        w_step_nxt = r_step + c_sw'(1);
                    end
                end else begin
                    w_res_nxt     = r_acc[DW-1:0];
                    w_res_err_nxt = 1'b0;
                    w_res_vld_nxt = 1'b1;
                    w_state_nxt   = ST_OUT;
                end
            end
            ST_OUT: begin
                if (r_rdy) begin
                    w_res_vld_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sticky overflow flag; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

`ifdef G_RX_STATS_EN
    logic [15:0] r_rx_cnt;
    logic [15:0] r_drop_cnt;

    // Free-running accepted/dropped sample counters, wrapping at 2^16
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_rx_cnt <= r_rx_cnt + 16'd1;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign rx_cnt   = r_rx_cnt;
    assign drop_cnt = r_drop_cnt;
`endif

    assign r     = r_res;
    assign r_vld = r_res_vld;
    assign r_err = r_res_err;
    assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_g_reduce_rx.sv
// ============================================================================
//  Module      : tb_g_reduce_rx
//  Description : Self-checking bench for g_reduce_rx: single-sample vector
//                table, overflow, stalled handshake, mid-operation reset and
//                a randomized stream against a modular-arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_g_reduce_rx;

    localparam int DW       = 16;
    localparam int MOD      = 3329;
    localparam int DEPTH    = 4;
    localparam int MAX_CORR = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW+2:0] g_in = '0;
    logic          g_vld = 1'b0;
    logic          r_rdy = 1'b0;
    logic [DW-1:0] r;
    logic          r_vld;
    logic          r_err;
    logic          ovf;
`ifdef G_RX_STATS_EN
    logic [15:0]   rx_cnt;
    logic [15:0]   drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    int exp_r_q [$];
    bit exp_e_q [$];
    int stim_q  [$];
    int issued;
    int done;

    typedef struct {
        int g;
        int er;
        bit ee;
        int lat;
    } vec_t;

    vec_t vecs [12];

    g_reduce_rx #(
        .DW       (DW),
        .MOD      (MOD),
        .DEPTH    (DEPTH),
        .MAX_CORR (MAX_CORR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .g_in     (g_in),
        .g_vld    (g_vld),
        .r        (r),
        .r_vld    (r_vld),
        .r_rdy    (r_rdy),
        .r_err    (r_err),
        .ovf      (ovf)
`ifdef G_RX_STATS_EN
        ,
        .rx_cnt   (rx_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the value is reducible iff it lies within MAX_CORR moduli of
    // [0, MOD); the result is then the mathematical residue.
    function automatic void ref_reduce(input int v, output int rr, output bit ee);
        int need;
        if (v < 0) need = (-v + MOD - 1) / MOD;
        else       need = v / MOD;
        if (need > MAX_CORR) begin
            rr = 0;
            ee = 1'b1;
        end else begin
            rr = ((v % MOD) + MOD) % MOD;
            ee = 1'b0;
        end
    endfunction

    function automatic int rand_val();
        int v;
        case ($urandom % 4)
            0:       v = int'($urandom_range(MOD - 1, 0));
            1:       v = int'($urandom_range(10 * MOD, 0)) - 5 * MOD;
            2:       v = int'($urandom_range(524287, 0)) - 262144;
            default: v = (int'($urandom_range(10, 0)) - 5) * MOD - int'($urandom_range(1, 0));
        endcase
        return v;
    endfunction

    // Drive queued samples and drain results. rdy_mode: 0 always ready,
    // 1 toggling, 2 random. Strobes only when the pipeline provably has room.
    task automatic run_stream(input int rdy_mode, input int strobe_pct, input int budget);
        int cyc = 0;
        bit held = 1'b0;
        int held_r = 0;
        bit held_e = 1'b0;
        int er;
        bit ee;
        int v;
        while ((stim_q.size() > 0 || done < issued) && cyc < budget) begin
            if (held) begin
                check("hold_vld", r_vld, 1);
                check("hold_r", r, held_r);
                check("hold_err", r_err, held_e);
            end
            if (stim_q.size() > 0 && (issued - done) < DEPTH &&
                int'($urandom_range(99, 0)) < strobe_pct) begin
                v = stim_q.pop_front();
                g_in = 19'(v);
                g_vld = 1'b1;
                ref_reduce(v, er, ee);
                exp_r_q.push_back(er);
                exp_e_q.push_back(ee);
                issued++;
            end else begin
                g_vld = 1'b0;
            end
            case (rdy_mode)
                0:       r_rdy = 1'b1;
                1:       r_rdy = ~r_rdy;
                default: r_rdy = ($urandom % 2) == 1;
            endcase
            held = 1'b0;
            if (r_vld) begin
                if (r_rdy) begin
                    if (exp_r_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        check("stream_r", r, exp_r_q.pop_front());
                        check("stream_err", r_err, exp_e_q.pop_front());
                    end
                    done++;
                end else begin
                    held = 1'b1;
                    held_r = r;
                    held_e = r_err;
                end
            end
            tick();
            cyc++;
        end
        g_vld = 1'b0;
        if (cyc >= budget) check("stream_timeout", cyc, -1);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{3328,    3328, 1'b0, 2};
        vecs[1]  = '{5000,    1671, 1'b0, 3};
        vecs[2]  = '{-100,    3229, 1'b0, 3};
        vecs[3]  = '{20000,   0,    1'b1, 6};
        vecs[4]  = '{0,       0,    1'b0, 2};
        vecs[5]  = '{3329,    0,    1'b0, 3};
        vecs[6]  = '{-13316,  0,    1'b0, 6};
        vecs[7]  = '{-13317,  0,    1'b1, 6};
        vecs[8]  = '{13315,   3328, 1'b0, 5};
        vecs[9]  = '{16645,   0,    1'b1, 6};
        vecs[10] = '{13316,   0,    1'b0, 6};
        vecs[11] = '{-262144, 0,    1'b1, 6};

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_r", r, 0);
        check("rst_r_vld", r_vld, 0);
        check("rst_r_err", r_err, 0);
        check("rst_ovf", ovf, 0);
`ifdef G_RX_STATS_EN
        check("rst_rx_cnt", rx_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Single-sample vectors: value, error flag and latency
        r_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check("vec_idle", r_vld, 0);
            g_in = 19'(vecs[i].g);
            g_vld = 1'b1;
            tick();
            g_vld = 1'b0;
            lat = 0;
            while (!r_vld && lat < 20) begin
                tick();
                lat++;
            end
            check("vec_lat", lat, vecs[i].lat);
            check("vec_r", r, vecs[i].er);
            check("vec_err", r_err, vecs[i].ee);
            tick();
            check("vec_vld_drop", r_vld, 0);
            tick();
        end

        // Burst of 6 while stalled: one held in the pipe, 4 buffered, 1 lost
        r_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            g_in = 19'(i);
            g_vld = 1'b1;
            tick();
        end
        g_vld = 1'b0;
        check("ovf_set", ovf, 1);
        check("ovf_head_vld", r_vld, 1);
        check("ovf_head_r", r, 1);
`ifdef G_RX_STATS_EN
        check("ovf_drop_cnt", drop_cnt, 1);
`endif
        issued = 5;
        done = 0;
        for (int i = 1; i <= 5; i++) begin
            exp_r_q.push_back(i);
            exp_e_q.push_back(1'b0);
        end
        run_stream(0, 0, 200);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (r_vld) seen++;
            tick();
        end
        check("ovf_no_sixth", seen, 0);
        check("ovf_sticky", ovf, 1);

        // Reset while correcting with two samples buffered
        r_rdy = 1'b1;
        g_in = 19'(13000); g_vld = 1'b1; tick();
        g_in = 19'(1);                   tick();
        g_in = 19'(2);                   tick();
        g_vld = 1'b0;
        check("pre_rst_ovf", ovf, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_ovf", ovf, 0);
        check("async_rst_vld", r_vld, 0);
        check("async_rst_r", r, 0);
        check("async_rst_err", r_err, 0);
`ifdef G_RX_STATS_EN
        check("async_rst_rx_cnt", rx_cnt, 0);
        check("async_rst_drop_cnt", drop_cnt, 0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (r_vld) seen++;
            tick();
        end
        check("no_stale_result", seen, 0);
        exp_r_q.delete();
        exp_e_q.delete();
        issued = 0;
        done = 0;

        // Four back-to-back samples with ready toggling every cycle
        stim_q.push_back(100);
        stim_q.push_back(4000);
        stim_q.push_back(-5);
        stim_q.push_back(7000);
        r_rdy = 1'b0;
        run_stream(1, 100, 300);
        check("toggle_count", done, 4);

        // Randomized stream against the model
        for (int i = 0; i < 150; i++) stim_q.push_back(rand_val());
        issued = 0;
        done = 0;
        run_stream(2, 60, 20000);
        check("rand_count", done, 150);
        check("rand_no_ovf", ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
